fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the instruction memory. Owns the 6-bit program counter, drives the memory's address and enable, captures each returned 16-bit instruction with its address into a small prefetch queue, and presents it to decode over a valid/ready handshake. Handles branch/jump redirect with queue flush and stops fetching on a HALT opcode until resumed.

## Interface
- PC_W, 6, program counter / instruction memory address width
- INSTR_W, 16, instruction width
- QDEPTH, 2, prefetch queue entries; power of two, 2..8
- RESET_PC, 0, PC value loaded on reset
- HALT_OPCODE, 4'hF, value of instr[15:12] that halts fetch

- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- pc  out  PC_W  address to instruction memory
- mem_en  out  1  enable to instruction memory
- mem_instr  in  INSTR_W  instruction read from memory at pc, valid same cycle as pc while mem_en=1
- redirect  in  1  taken branch/jump from execute
- redirect_pc  in  PC_W  target address, sampled when redirect=1
- instr  out  INSTR_W  head-of-queue instruction
- instr_pc  out  PC_W  address of instr
- instr_valid  out  1  queue head valid
- instr_ready  in  1  decode accepts head
- resume  in  1  leave HALT
- halted  out  1  fetch stopped on HALT
- fetch_count  out  16  instructions delivered to decode

## Operation
- FSM states: RUN, HALT. Reset → RUN.
- mem_en = (state==RUN) && (count<QDEPTH) && !redirect && !reset; combinational.
- Push: on posedge with mem_en=1, write {pc, mem_instr} at tail; pc <= pc+1, wrapping 63→0.
- Pop: on posedge with instr_valid && instr_ready, advance head.
- Push and pop same cycle: both occur, count unchanged. Full queue: no push, even if pop occurs that cycle.
- HALT detect: pushed instruction with mem_instr[15:12]==HALT_OPCODE is still queued and pc still increments; state → HALT. halted = (state==HALT).
- HALT: mem_en=0; queue drains normally. resume=1 → RUN next cycle, fetch restarts at current pc. resume in RUN ignored.
- Redirect (highest priority, either state): queue flushed (count→0), pc <= redirect_pc, no push, no pop, instr_valid forced 0 that cycle, state unchanged. Redirect and HALT detect same cycle: redirect wins, no push, no state change.
- instr/instr_pc show head entry when valid, 0 when empty.
- reset mid-operation: all state returns to reset values next edge; in-flight entries lost.

## Timing
- Reset values: pc=RESET_PC, mem_en=0 during reset cycle, instr=0, instr_pc=0, instr_valid=0, halted=0, fetch_count=0, queue empty.
- Fetch-to-decode latency: instruction at pc fetched in cycle N is instr_valid in cycle N+1.
- Throughput: 1 instruction/cycle with instr_ready held high.
- Redirect in cycle N: target instruction fetched cycle N+1, valid cycle N+2.
- instr_valid never depends combinationally on instr_ready.

## Configuration
- FETCH_PERF_CNT_EN defined: fetch_count increments on each pop handshake, wraps 65535→0, cleared by reset.
- Undefined: counter logic removed, fetch_count tied to 0.

## Structure
- Shared package cpu_pkg: PC_W, INSTR_W, opcode field position [15:12], HALT opcode constant, fetch FSM state encoding.
- One sub-module: fetch_queue — circular FIFO of {PC_W+INSTR_W} bits, QDEPTH entries, with push, pop, flush, count/full/empty.
- pc register, FSM, mem_en logic and counter stay in fetch_unit.

## Test plan
- Reset, memory 0..5 non-HALT, instr_ready=1 → pc 0,1,2.. each cycle; instr_pc 0 valid cycle 1 after reset release, then 1/cycle.
- instr_ready=0 from start, QDEPTH=2 → exactly two pushes (pc 0,1), mem_en=0 from third cycle, pc holds 2; ready=1 → 0,1,2 delivered in order.
- Queue holding 2 entries, redirect=1 redirect_pc=6'd40 → instr_valid=0 that cycle, instr_pc=40 valid two cycles later, old entries never seen.
- HALT (16'hF000) at address 3 → entries 0..3 delivered, halted=1, mem_en=0, pc=4; resume=1 → instr_pc=4 delivered.
- pc=63 with fetch running → next pc 0, instr_pc 63 followed by 0.
- FETCH_PERF_CNT_EN set, 10 handshakes then reset mid-stream → fetch_count=10, then 0 and instr_valid=0 after reset edge.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared constants for the CPU front end: default address and
//            instruction widths, opcode field position, the HALT opcode and
//            the fetch FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int c_pc_w    = 6;
    localparam int c_instr_w = 16;

    // Opcode field occupies the top nibble of every instruction.
    localparam int c_opc_msb = 15;
    localparam int c_opc_lsb = 12;

    localparam logic [3:0] c_halt_opcode = 4'hF;

    // Fetch FSM state encoding.
    localparam logic [0:0] c_st_run  = 1'b0;
    localparam logic [0:0] c_st_halt = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Circular prefetch FIFO of DEPTH entries, WIDTH bits each.
//            Synchronous flush empties the queue; flush has priority over
//            push and pop. Head data reads as zero when the queue is empty.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            i_flush           - discard all entries
//            i_push, i_wr_data - write an entry at the tail (ignored if full)
//            i_pop             - advance the head (ignored if empty)
//            o_rd_data         - head entry, zero when empty
//            o_full, o_empty   - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int               c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_ptr_w:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == c_depth);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rd_data = o_empty ? '0 : r_mem[r_head];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_do_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!rst && !i_flush && w_do_push) begin
            r_mem[r_tail] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Owns the program counter, drives the
//            instruction memory, buffers returned instructions (with their
//            address) in a prefetch queue and hands them to decode over a
//            valid/ready handshake. Supports redirect with flush and a HALT
//            opcode that stops fetching until resume.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            pc, mem_en, mem_instr      - instruction memory interface
//            redirect, redirect_pc      - taken branch/jump from execute
//            instr, instr_pc,
//            instr_valid, instr_ready   - decode handshake
//            resume, halted             - HALT control/status
//            fetch_count                - delivered-instruction counter
// Config   : FETCH_PERF_CNT_EN - when defined, fetch_count counts decode
//            handshakes (wrapping); otherwise fetch_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W        = c_pc_w,
    parameter int              INSTR_W     = c_instr_w,
    parameter int              QDEPTH      = 2,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [3:0]      HALT_OPCODE = c_halt_opcode
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    pc,
    output logic               mem_en,
    input  logic [INSTR_W-1:0] mem_instr,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               resume,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    logic [PC_W-1:0] r_pc;
    logic [0:0]      r_state;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_is_halt;
    logic [PC_W+INSTR_W-1:0] w_head;

    // Redirect suppresses both fetch and delivery in the cycle it is seen;
    // reset suppresses fetch so no memory access happens during reset.
    assign mem_en      = (r_state == c_st_run) && !w_full && !redirect && !reset;
    assign instr_valid = !w_empty && !redirect;
    assign w_pop       = instr_valid && instr_ready;
    assign w_is_halt   = (mem_instr[c_opc_msb:c_opc_lsb] == HALT_OPCODE);

    assign pc                = r_pc;
    assign halted            = (r_state == c_st_halt);
    assign {instr_pc, instr} = w_head;

    fetch_queue #(
        .WIDTH (PC_W + INSTR_W),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (reset),
        .i_flush   (redirect),
        .i_push    (mem_en),
        .i_wr_data ({r_pc, mem_instr}),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // PC and fetch FSM. Redirect overrides everything, including a HALT
    // opcode arriving in the same cycle (that instruction is not pushed).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_state <= c_st_run;
        end else if (redirect) begin
            r_pc    <= redirect_pc;
        end else begin
            if (mem_en) begin
                r_pc <= r_pc + 1'b1;
            end
            case (r_state)
                c_st_run: begin
                    if (mem_en && w_is_halt) begin
                        r_state <= c_st_halt;
                    end
                end
                c_st_halt: begin
                    if (resume) begin
                        r_state <= c_st_run;
                    end
                end
                default: r_state <= c_st_run;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetch_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= '0;
        end else if (w_pop) begin
            r_fetch_count <= r_fetch_count + 1'b1;
        end
    end

    assign fetch_count = r_fetch_count;
`else
    assign fetch_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A bench-side memory image
//            feeds the DUT; expected fetch addresses are queued as stimulus
//            is driven and compared as decode handshakes complete.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int PC_W    = 6;
    localparam int INSTR_W = 16;
    localparam int QDEPTH  = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [PC_W-1:0]    pc;
    logic               mem_en;
    logic [INSTR_W-1:0] mem_instr;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               resume;
    logic               halted;
    logic [15:0]        fetch_count;

    logic [INSTR_W-1:0] mem [64];
    logic [PC_W-1:0]    sb [$];
    logic [PC_W-1:0]    exp_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mem_instr = mem[pc];

    fetch_unit #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .QDEPTH  (QDEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .mem_en      (mem_en),
        .mem_instr   (mem_instr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .resume      (resume),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse; returns 2ns into cycle 0 after reset release.
    task automatic start(input logic rdy);
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        resume      = 1'b0;
        instr_ready = rdy;
        sb.delete();
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        resume      = 1'b0;
        instr_ready = 1'b1;
        step();
        step();
        checks++;
        if (pc !== 6'd0) begin failures++; $display("FAIL reset_pc: got %0d, expected 0", pc); end
        checks++;
        if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en: got %b, expected 0", mem_en); end
        checks++;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b, expected 0", instr_valid); end
        checks++;
        if (instr !== 16'h0 || instr_pc !== 6'd0) begin
            failures++; $display("FAIL reset_head: got instr=%h pc=%0d, expected 0/0", instr, instr_pc);
        end
        checks++;
        if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b, expected 0", halted); end
        checks++;
        if (fetch_count !== 16'd0) begin failures++; $display("FAIL reset_count: got %0d, expected 0", fetch_count); end
    endtask

    task automatic test_stream();
        start(1'b1);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (pc !== 6'(k) || mem_en !== 1'b1) begin
                failures++; $display("FAIL stream_pc: got pc=%0d mem_en=%b, expected pc=%0d mem_en=1", pc, mem_en, k);
            end
            sb.push_back(6'(k));
            if (k == 0) begin
                checks++;
                if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_latency: valid=%b in cycle 0, expected 0", instr_valid); end
            end else begin
                exp_pc = sb.pop_front();
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== mem[exp_pc]) begin
                    failures++;
                    $display("FAIL stream_deliver: got valid=%b pc=%0d instr=%h, expected valid=1 pc=%0d instr=%h",
                             instr_valid, instr_pc, instr, exp_pc, mem[exp_pc]);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        start(1'b0);
        sb.push_back(6'd0);
        step();
        sb.push_back(6'd1);
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (mem_en !== 1'b0 || pc !== 6'd2) begin
                failures++; $display("FAIL bp_full: got mem_en=%b pc=%0d, expected mem_en=0 pc=2", mem_en, pc);
            end
            if (k == 0) step();
        end
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 6'd0) begin
            failures++; $display("FAIL bp_head: got valid=%b pc=%0d, expected valid=1 pc=0", instr_valid, instr_pc);
        end
        instr_ready = 1'b1;
        sb.push_back(6'd2);
        for (int cyc = 0; cyc < 12 && sb.size() > 0; cyc++) begin
            if (instr_valid && instr_ready) begin
                exp_pc = sb.pop_front();
                checks++;
                if (instr_pc !== exp_pc || instr !== mem[exp_pc]) begin
                    failures++; $display("FAIL bp_order: got pc=%0d instr=%h, expected pc=%0d instr=%h", instr_pc, instr, exp_pc, mem[exp_pc]);
                end
            end
            step();
        end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL bp_timeout: %0d entries undelivered, expected 0", sb.size()); end
    endtask

    task automatic test_redirect();
        start(1'b0);
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 6'd40;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || mem_en !== 1'b0) begin
            failures++; $display("FAIL redir_cycle: got valid=%b mem_en=%b, expected 0/0", instr_valid, mem_en);
        end
        step();
        redirect    = 1'b0;
        instr_ready = 1'b1;
        #1;
        checks++;
        if (pc !== 6'd40 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL redir_target: got pc=%0d valid=%b, expected pc=40 valid=0", pc, instr_valid);
        end
        sb.push_back(6'd40);
        sb.push_back(6'd41);
        sb.push_back(6'd42);
        step();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 6'd40) begin
            failures++; $display("FAIL redir_latency: got valid=%b pc=%0d, expected valid=1 pc=40", instr_valid, instr_pc);
        end
        for (int cyc = 0; cyc < 12 && sb.size() > 0; cyc++) begin
            if (instr_valid && instr_ready) begin
                exp_pc = sb.pop_front();
                checks++;
                if (instr_pc !== exp_pc || instr !== mem[exp_pc]) begin
                    failures++; $display("FAIL redir_order: got pc=%0d instr=%h, expected pc=%0d instr=%h", instr_pc, instr, exp_pc, mem[exp_pc]);
                end
            end
            step();
        end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL redir_timeout: %0d entries undelivered, expected 0", sb.size()); end
    endtask

    task automatic test_halt();
        logic [INSTR_W-1:0] saved;
        saved  = mem[3];
        mem[3] = 16'hF000;
        start(1'b1);
        for (int k = 0; k < 4; k++) sb.push_back(6'(k));
        for (int cyc = 0; cyc < 12 && sb.size() > 0; cyc++) begin
            if (instr_valid && instr_ready) begin
                exp_pc = sb.pop_front();
                checks++;
                if (instr_pc !== exp_pc || instr !== mem[exp_pc]) begin
                    failures++; $display("FAIL halt_order: got pc=%0d instr=%h, expected pc=%0d instr=%h", instr_pc, instr, exp_pc, mem[exp_pc]);
                end
            end
            step();
        end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL halt_timeout: %0d entries undelivered, expected 0", sb.size()); end
        step();
        checks++;
        if (halted !== 1'b1 || mem_en !== 1'b0 || pc !== 6'd4 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt_state: got halted=%b mem_en=%b pc=%0d valid=%b, expected 1/0/4/0", halted, mem_en, pc, instr_valid);
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || mem_en !== 1'b1 || pc !== 6'd4) begin
            failures++; $display("FAIL halt_resume: got halted=%b mem_en=%b pc=%0d, expected 0/1/4", halted, mem_en, pc);
        end
        sb.push_back(6'd4);
        for (int cyc = 0; cyc < 8 && sb.size() > 0; cyc++) begin
            if (instr_valid && instr_ready) begin
                exp_pc = sb.pop_front();
                checks++;
                if (instr_pc !== exp_pc || instr !== mem[exp_pc]) begin
                    failures++; $display("FAIL resume_order: got pc=%0d instr=%h, expected pc=%0d instr=%h", instr_pc, instr, exp_pc, mem[exp_pc]);
                end
            end
            step();
        end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL resume_timeout: %0d entries undelivered, expected 0", sb.size()); end
        mem[3] = saved;
    endtask

    task automatic test_wrap();
        start(1'b1);
        redirect    = 1'b1;
        redirect_pc = 6'd62;
        step();
        redirect = 1'b0;
        #1;
        checks++;
        if (pc !== 6'd62) begin failures++; $display("FAIL wrap_start: got pc=%0d, expected 62", pc); end
        sb.push_back(6'd62);
        sb.push_back(6'd63);
        sb.push_back(6'd0);
        sb.push_back(6'd1);
        for (int cyc = 0; cyc < 12 && sb.size() > 0; cyc++) begin
            if (instr_valid && instr_ready) begin
                exp_pc = sb.pop_front();
                checks++;
                if (instr_pc !== exp_pc || instr !== mem[exp_pc]) begin
                    failures++; $display("FAIL wrap_order: got pc=%0d instr=%h, expected pc=%0d instr=%h", instr_pc, instr, exp_pc, mem[exp_pc]);
                end
            end
            step();
        end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL wrap_timeout: %0d entries undelivered, expected 0", sb.size()); end
    endtask

    task automatic test_perf_count();
        int          hs;
        logic [15:0] exp_cnt;
        hs = 0;
`ifdef FETCH_PERF_CNT_EN
        exp_cnt = 16'd10;
`else
        exp_cnt = 16'd0;
`endif
        start(1'b1);
        for (int cyc = 0; cyc < 40 && hs < 10; cyc++) begin
            if (instr_valid && instr_ready) hs++;
            step();
        end
        checks++;
        if (hs != 10) begin failures++; $display("FAIL perf_timeout: got %0d handshakes, expected 10", hs); end
        checks++;
        if (fetch_count !== exp_cnt) begin failures++; $display("FAIL perf_count: got %0d, expected %0d", fetch_count, exp_cnt); end
        reset = 1'b1;
        step();
        checks++;
        if (fetch_count !== 16'd0 || instr_valid !== 1'b0 || pc !== 6'd0) begin
            failures++;
            $display("FAIL perf_reset: got count=%0d valid=%b pc=%0d, expected 0/0/0", fetch_count, instr_valid, pc);
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            // Opcodes 1..14 only, so no accidental HALT in the image.
            mem[i] = {4'(1 + (i % 14)), 6'(i ^ 6'h2A), 6'(i)};
        end
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_perf_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
